// File: rtl/switch_bus_driver_if.sv
// Register-port bus between the bring-up driver (master) and the switch (slave).
interface switch_bus_driver_if;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;

  modport master (
    output address, writedata, write, read, chipselect,
    input  readdata
  );

  modport slave (
    input  address, writedata, write, read, chipselect,
    output readdata
  );
endinterface

// File: rtl/switch_bus_driver.sv
// switch_bus_driver: hardware stand-in for the switch's software driver.
// On start: load metadata words into ingress ports, set the experimenting
// bit, poll the egress readback for run_cycles clocks, clear the bit, and
// report how many non-zero words came back.
// Optional build macro SWITCH_DRIVER_LFSR_DST_EN: metadata dst field comes
// from a 16-bit LFSR instead of (src + 1) mod 4.
module switch_bus_driver #(
  parameter int META_BASE_ADDR = 0,
  parameter int CTRL_ADDR      = 4,
  parameter int RX_ADDR        = 5,
  parameter int POLL_GAP       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         num_packets,
  input  logic [31:0]         run_cycles,
  output logic                busy,
  output logic                done,
  output logic [15:0]         rx_count,
  switch_bus_driver_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_STOP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        ph_q, ph_d;          // write phase: 0 = strobe cycle, 1 = idle cycle
  logic [15:0] k_q, k_d;            // index of the load write in flight
  logic [15:0] num_q, num_d;
  logic [31:0] cnt_q, cnt_d;        // holds run_cycles, counts down through RUN
  logic [3:0]  gcnt_q, gcnt_d;      // cycles since the last poll strobe
  logic        rd_pend_q;
  logic [15:0] rx_q;
  logic        busy_q, busy_d, done_q, done_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d, rd_q, rd_d, cs_q, cs_d;

  logic        rx_clr, load_wr, ctrl_wr, ctrl_val, rd_iss;
  logic [15:0] k_iss;
  logic [1:0]  dst;

`ifdef SWITCH_DRIVER_LFSR_DST_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d, lfsr_cur;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting right
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
`endif

  // Next state plus the registered bus/status values for the next cycle
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    k_d      = k_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    rx_clr   = 1'b0;
    load_wr  = 1'b0;
    k_iss    = k_q;
    ctrl_wr  = 1'b0;
    ctrl_val = 1'b0;
    rd_iss   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d  = num_packets;
          cnt_d  = run_cycles;
          k_d    = '0;
          ph_d   = 1'b0;
          rx_clr = 1'b1;
          if (num_packets == 16'd0) begin
            state_d  = S_START;
            ctrl_wr  = 1'b1;
            ctrl_val = 1'b1;
          end else begin
            state_d = S_LOAD;
            load_wr = 1'b1;
            k_iss   = '0;
          end
        end
      end
      S_LOAD: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (k_q + 16'd1 == num_q) begin
            state_d  = S_START;
            ctrl_wr  = 1'b1;
            ctrl_val = 1'b1;
          end else begin
            k_d     = k_q + 16'd1;
            k_iss   = k_q + 16'd1;
            load_wr = 1'b1;
          end
        end
      end
      S_START: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (cnt_q == 32'd0) begin
            state_d = S_STOP;
            ctrl_wr = 1'b1;
          end else begin
            state_d = S_RUN;
            rd_iss  = 1'b1;
            gcnt_d  = '0;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          // a poll still in flight is sampled during STOP
          state_d = S_STOP;
          ph_d    = 1'b0;
          ctrl_wr = 1'b1;
        end else if (gcnt_q == 4'(POLL_GAP)) begin
          rd_iss = 1'b1;
          gcnt_d = '0;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      S_STOP: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SWITCH_DRIVER_LFSR_DST_EN
    lfsr_cur = (state_q == S_IDLE) ? LFSR_SEED : lfsr_q;
    dst      = lfsr_cur[1:0];
    lfsr_d   = load_wr ? lfsr_next(lfsr_cur) : lfsr_q;
`else
    dst      = k_iss[1:0] + 2'd1;
`endif

    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    addr_d  = '0;
    wdata_d = '0;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    if (load_wr) begin
      cs_d    = 1'b1;
      wr_d    = 1'b1;
      addr_d  = 3'(META_BASE_ADDR + int'(k_iss[1:0]));
      wdata_d = {k_iss, 12'h000, k_iss[1:0], dst};
    end else if (ctrl_wr) begin
      cs_d    = 1'b1;
      wr_d    = 1'b1;
      addr_d  = 3'(CTRL_ADDR);
      wdata_d = {31'h0, ctrl_val};
    end else if (rd_iss) begin
      cs_d    = 1'b1;
      rd_d    = 1'b1;
      addr_d  = 3'(RX_ADDR);
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      k_q     <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cs_q    <= 1'b0;
`ifdef SWITCH_DRIVER_LFSR_DST_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
`ifdef SWITCH_DRIVER_LFSR_DST_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Readback counter: readdata is valid the cycle after the read strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q <= 1'b0;
      rx_q      <= '0;
    end else begin
      rd_pend_q <= rd_q;
      if (rx_clr)
        rx_q <= '0;
      else if (rd_pend_q && (bus.readdata != 32'd0) && (rx_q != 16'hFFFF))
        rx_q <= rx_q + 16'd1;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign rx_count       = rx_q;
  assign bus.address    = addr_q;
  assign bus.writedata  = wdata_q;
  assign bus.write      = wr_q;
  assign bus.read       = rd_q;
  assign bus.chipselect = cs_q;

endmodule
